// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : funct3 load/store encodings and FSM state type for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic f3_load_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module      : data_mem_responder_if
// Description : Core-to-memory request/response bundle for the data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [2:0]        funct3;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic [3:0]        byte_en;

  modport master (
    output req_read, req_write, addr, wdata, funct3,
    input  rdata, ready, err, byte_en
  );

  modport slave (
    input  req_read, req_write, addr, wdata, funct3,
    output rdata, ready, err, byte_en
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder_load_store_align.sv
// ============================================================================
// Module      : load_store_align
// Description : Byte-lane mask, store-data shift and load alignment/extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_align
  import data_mem_responder_pkg::*;
(
  input  wire  logic [2:0]  i_funct3,
  input  wire  logic [1:0]  i_offset,
  input  wire  logic [31:0] i_wdata,
  input  wire  logic [31:0] i_rword,
  output logic [3:0]        o_lanes,
  output logic [31:0]       o_wdata_sh,
  output logic [31:0]       o_rdata_ext,
  output logic              o_misaligned
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rsh;

  assign w_shamt    = {i_offset, 3'b000};
  assign w_rsh      = i_rword >> w_shamt;
  assign o_wdata_sh = i_wdata << w_shamt;

  always_comb begin
    o_lanes      = 4'b0000;
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00: o_lanes = 4'b0001 << i_offset;
      2'b01: begin
        o_lanes      = 4'b0011 << i_offset;
        o_misaligned = i_offset[0];
      end
      2'b10: begin
        o_lanes      = 4'b1111;
        o_misaligned = |i_offset;
      end
      default: o_lanes = 4'b0000;
    endcase
  end

  always_comb begin
    o_rdata_ext = 32'h0;
    case (i_funct3)
      F3_LB:   o_rdata_ext = {{24{w_rsh[7]}}, w_rsh[7:0]};
      F3_LH:   o_rdata_ext = {{16{w_rsh[15]}}, w_rsh[15:0]};
      F3_LW:   o_rdata_ext = w_rsh;
      F3_LBU:  o_rdata_ext = {24'h0, w_rsh[7:0]};
      F3_LHU:  o_rdata_ext = {16'h0, w_rsh[15:0]};
      default: o_rdata_ext = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Latency-programmable data-memory responder with byte-masked
//               stores and aligned, extended loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  data_mem_responder_if.slave  mem
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_accept;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic              r_rd;
  logic              r_wr;

  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic [3:0]  r_byte_en;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [3:0]       w_lanes;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_rdata_ext;
  logic             w_misaligned;
  logic             w_oor;
  logic             w_illegal;
  logic             w_err;
  logic             w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter holds the cycles still to spend in WAIT; entering WAIT requires it >= 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem.req_read || mem.req_write) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = (C_CNT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= mem.addr;
      r_wdata  <= mem.wdata;
      r_funct3 <= mem.funct3;
      r_rd     <= mem.req_read;
      r_wr     <= mem.req_write;
    end
  end

  assign w_idx   = r_addr[IDX_W+1:2];
  assign w_rword = r_mem[w_idx];

  load_store_align u_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_rword      (w_rword),
    .o_lanes      (w_lanes),
    .o_wdata_sh   (w_wdata_sh),
    .o_rdata_ext  (w_rdata_ext),
    .o_misaligned (w_misaligned)
  );

  assign w_oor     = (r_addr >> (IDX_W + 2)) != '0;
  assign w_illegal = (r_funct3[1:0] == 2'b11) || (r_rd && !f3_load_legal(r_funct3));
  assign w_err     = (r_rd && r_wr) || w_oor || w_misaligned || w_illegal;
  // Synchronous reset in the RESP cycle also blocks the commit.
  assign w_commit  = (r_state == ST_RESP) && r_wr && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lanes[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= 32'h0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_byte_en <= 4'b0000;
    end else begin
      r_ready <= (r_state == ST_RESP);
      if (r_state == ST_RESP) begin
        r_err     <= w_err;
        r_byte_en <= w_err ? 4'b0000 : w_lanes;
        r_rdata   <= (w_err || !r_rd) ? 32'h0 : w_rdata_ext;
      end
    end
  end

  assign mem.rdata   = r_rdata;
  assign mem.ready   = r_ready;
  assign mem.err     = r_err;
  assign mem.byte_en = r_byte_en;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench; two responders, LATENCY 1 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  data_mem_responder_if #(.ADDR_W(32)) bus1 ();
  data_mem_responder_if #(.ADDR_W(32)) bus4 ();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .mem (bus1)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .ADDR_W(32)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .mem (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    if (sel) begin
      bus4.req_read = rd; bus4.req_write = wr; bus4.addr = a; bus4.wdata = wd; bus4.funct3 = f3;
    end else begin
      bus1.req_read = rd; bus1.req_write = wr; bus1.addr = a; bus1.wdata = wd; bus1.funct3 = f3;
    end
  endtask

  // One request, dropped right after accept with scrambled bus values.
  task automatic op(input string tag, input bit sel, input logic rd, input logic wr,
                    input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                    input int exp_lat, input bit chk_rd, input logic [31:0] exp_rdata,
                    input logic exp_err, input logic [3:0] exp_be);
    int lat;
    logic rdy;
    lat = -1;
    @(negedge clk);
    drive(sel, rd, wr, a, wd, f3);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 3'b111);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      rdy = sel ? bus4.ready : bus1.ready;
      if (rdy) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (chk_rd) check({tag, "_rdata"}, sel ? bus4.rdata : bus1.rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, sel ? bus4.err : bus1.err}, {31'b0, exp_err});
    check({tag, "_byte_en"}, {28'b0, sel ? bus4.byte_en : bus1.byte_en}, {28'b0, exp_be});
    @(posedge clk); #1;
    check({tag, "_ready_one_cycle"}, {31'b0, sel ? bus4.ready : bus1.ready}, 32'h0);
  endtask

  initial begin
    bit saw_ready;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata1", bus1.rdata, 32'h0);
    check("rst_ready1", {31'b0, bus1.ready}, 32'h0);
    check("rst_err1", {31'b0, bus1.err}, 32'h0);
    check("rst_be1", {28'b0, bus1.byte_en}, 32'h0);
    check("rst_rdata4", bus4.rdata, 32'h0);
    check("rst_ready4", {31'b0, bus4.ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word store/load round trip, LATENCY=1
    op("sw10", 0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 0, 32'h0, 0, 4'b1111);
    op("lw10", 0, 1, 0, 32'h10, 32'h0, 3'b010, 1, 1, 32'hDEADBEEF, 0, 4'b1111);
    repeat (3) @(posedge clk);
    #1 check("rdata_hold", bus1.rdata, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    op("sb13", 0, 0, 1, 32'h13, 32'h0000_0080, 3'b000, 1, 0, 32'h0, 0, 4'b1000);
    op("lb13", 0, 1, 0, 32'h13, 32'h0, 3'b000, 1, 1, 32'hFFFFFF80, 0, 4'b1000);
    op("lbu13", 0, 1, 0, 32'h13, 32'h0, 3'b100, 1, 1, 32'h00000080, 0, 4'b1000);
    op("lw10b", 0, 1, 0, 32'h10, 32'h0, 3'b010, 1, 1, 32'h80ADBEEF, 0, 4'b1111);
    op("lb11", 0, 1, 0, 32'h11, 32'h0, 3'b000, 1, 1, 32'hFFFFFFBE, 0, 4'b0010);

    // Halfword store, loads, misaligned load and store
    op("sw20", 0, 0, 1, 32'h20, 32'h0000_0000, 3'b010, 1, 0, 32'h0, 0, 4'b1111);
    op("sh22", 0, 0, 1, 32'h22, 32'h0000_1234, 3'b001, 1, 0, 32'h0, 0, 4'b1100);
    op("lhu22", 0, 1, 0, 32'h22, 32'h0, 3'b101, 1, 1, 32'h00001234, 0, 4'b1100);
    op("lh21", 0, 1, 0, 32'h21, 32'h0, 3'b001, 1, 1, 32'h0, 1, 4'b0000);
    op("sh21", 0, 0, 1, 32'h21, 32'h0000_FFFF, 3'b001, 1, 0, 32'h0, 1, 4'b0000);
    op("lw20", 0, 1, 0, 32'h20, 32'h0, 3'b010, 1, 1, 32'h12340000, 0, 4'b1111);
    op("lh12", 0, 1, 0, 32'h12, 32'h0, 3'b001, 1, 1, 32'hFFFF80AD, 0, 4'b1100);

    // Error cases: conflicting strobes, out of range, illegal funct3
    op("both", 0, 1, 1, 32'h10, 32'h1111_1111, 3'b010, 1, 1, 32'h0, 1, 4'b0000);
    op("lw10c", 0, 1, 0, 32'h10, 32'h0, 3'b010, 1, 1, 32'h80ADBEEF, 0, 4'b1111);
    op("sw0", 0, 0, 1, 32'h0, 32'h0000_0000, 3'b010, 1, 0, 32'h0, 0, 4'b1111);
    op("sw_oor", 0, 0, 1, 32'h400, 32'h2222_2222, 3'b010, 1, 0, 32'h0, 1, 4'b0000);
    op("lw0", 0, 1, 0, 32'h0, 32'h0, 3'b010, 1, 1, 32'h0, 0, 4'b1111);
    op("lw_oor", 0, 1, 0, 32'h400, 32'h0, 3'b010, 1, 1, 32'h0, 1, 4'b0000);
    op("ld_f3_110", 0, 1, 0, 32'h10, 32'h0, 3'b110, 1, 1, 32'h0, 1, 4'b0000);
    op("sw_misal", 0, 0, 1, 32'h12, 32'h3333_3333, 3'b010, 1, 0, 32'h0, 1, 4'b0000);

    // LATENCY=4 with bus scrambled during WAIT
    op("sw40_l4", 1, 0, 1, 32'h40, 32'hCAFEF00D, 3'b010, 4, 0, 32'h0, 0, 4'b1111);
    op("lw40_l4", 1, 1, 0, 32'h40, 32'h0, 3'b010, 4, 1, 32'hCAFEF00D, 0, 4'b1111);

    // Reset during WAIT aborts the store
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0BADBEEF, 3'b010);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.ready) saw_ready = 1'b1;
    end
    check("abort_no_ready", {31'b0, saw_ready}, 32'h0);
    check("abort_rdata", bus4.rdata, 32'h0);
    check("abort_err", {31'b0, bus4.err}, 32'h0);
    check("abort_be", {28'b0, bus4.byte_en}, 32'h0);
    op("lw40_after", 1, 1, 0, 32'h40, 32'h0, 3'b010, 4, 1, 32'hCAFEF00D, 0, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
